// File: rtl/dig_map_if.sv
// Player/frame inputs and tunnel-map outputs of the dig map, bundled for the
// gameplay core (master) and the map block (slave).
interface dig_map_if;
    logic                frame_clk;
    logic [9:0]          Player_X;
    logic [9:0]          Player_Y;
    logic                dig_en;
    logic                level_load;
    logic [31:0][23:0]   dug_state;
    logic                busy;
    logic                tile_dug;
    logic [9:0]          dug_count;

    modport master (
        output frame_clk, Player_X, Player_Y, dig_en, level_load,
        input  dug_state, busy, tile_dug, dug_count
    );

    modport slave (
        input  frame_clk, Player_X, Player_Y, dig_en, level_load,
        output dug_state, busy, tile_dug, dug_count
    );
endinterface

// File: rtl/dig_map.sv
// Tunnel bitmap for the dig game: marks the tile under the player once per
// frame while digging, and reinitialises the whole map with a 32-cycle
// column sweep on level load.
module dig_map #(
    parameter logic [9:0] MAP_TOP   = 10'd96,
    parameter logic [4:0] START_COL = 5'd16
) (
    input  logic     Clk,
    input  logic     Reset,
    dig_map_if.slave bus
);

    typedef enum logic {RUN, SWEEP} state_t;

    localparam logic [9:0] COUNT_MAX = 10'd768;

    logic [1:0]        rst_sync_q;
    logic              rst_n;

    state_t            state_q, state_d;
    logic [4:0]        sc_q, sc_d;
    logic [31:0][23:0] dug_state_q, dug_state_d;
    logic [9:0]        count_q, count_d;
    logic              tile_dug_q, tile_dug_d;
    logic              fclk_dly_q, fclk_dly_d;
    logic              frame_edge_q, frame_edge_d;

    logic [4:0]        col;
    logic [4:0]        row;
    logic [10:0]       y_ext;
    logic [10:0]       top_ext;
    logic              in_map;

    // Reset asserts immediately, releases two Clk edges later on a clean edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    // Tile coordinates of the player and the in-map window test.
    always_comb begin
        col     = 5'(bus.Player_X >> 4);
        row     = 5'((bus.Player_Y - MAP_TOP) >> 4);
        y_ext   = {1'b0, bus.Player_Y};
        top_ext = {1'b0, MAP_TOP};
        in_map  = (bus.Player_X <= 10'd511) &&
                  (y_ext >= top_ext) &&
                  (y_ext <= top_ext + 11'd383);
    end

    // Rising-edge detect of the frame tick, both stages registered.
    always_comb begin
        fclk_dly_d   = bus.frame_clk;
        frame_edge_d = bus.frame_clk & ~fclk_dly_q;
    end

    // Next-state logic: level load has priority over digging; the sweep
    // rewrites one column per cycle and ignores frame edges.
    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        dug_state_d = dug_state_q;
        count_d     = count_q;
        tile_dug_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.level_load) begin
                    state_d = SWEEP;
                    sc_d    = '0;
                    count_d = '0;
                end else if (frame_edge_q && bus.dig_en && in_map &&
                             !dug_state_q[col][row]) begin
                    dug_state_d[col][row] = 1'b1;
                    tile_dug_d            = 1'b1;
                    if (count_q != COUNT_MAX) count_d = count_q + 10'd1;
                end
            end
            SWEEP: begin
                if (sc_q == START_COL) begin
                    dug_state_d[sc_q] = 24'h00000F;
                    count_d           = 10'd4;
                end else begin
                    dug_state_d[sc_q] = '0;
                end
                if (bus.level_load)      sc_d    = '0;
                else if (sc_q == 5'd31)  state_d = RUN;
                else                     sc_d    = sc_q + 5'd1;
            end
            default: state_d = RUN;
        endcase
    end

    // State, map and counters, cleared asynchronously by reset.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            sc_q         <= '0;
            dug_state_q  <= '0;
            count_q      <= '0;
            tile_dug_q   <= 1'b0;
            fclk_dly_q   <= 1'b0;
            frame_edge_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sc_q         <= sc_d;
            dug_state_q  <= dug_state_d;
            count_q      <= count_d;
            tile_dug_q   <= tile_dug_d;
            fclk_dly_q   <= fclk_dly_d;
            frame_edge_q <= frame_edge_d;
        end
    end

    assign bus.dug_state = dug_state_q;
    assign bus.busy      = (state_q == SWEEP);
    assign bus.tile_dug  = tile_dug_q;
    assign bus.dug_count = count_q;

endmodule

// File: tb/tb_dig_map.sv
// Directed bench for dig_map: digging, repeat digs, level sweep, restart,
// out-of-map rejection, load/dig collision and asynchronous reset.
module tb_dig_map;

    logic Clk;
    logic Reset;

    dig_map_if bus();

    dig_map #(.MAP_TOP(10'd96), .START_COL(5'd16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int unsigned pass_cnt;
    int unsigned total_cnt;
    int unsigned pulse_cnt;
    logic [31:0][23:0] exp_map;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (bus.tile_dug === 1'b1) pulse_cnt++;

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic frame_pulse();
        bus.frame_clk = 1'b1;
        tick();
        bus.frame_clk = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.frame_clk = 1'b0; bus.Player_X = '0; bus.Player_Y = '0;
        bus.dig_en = 1'b0; bus.level_load = 1'b0;
        tick(3);
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.tile_dug !== 1'b0) $display("FAIL reset_tile_dug: got %0b expected 0", bus.tile_dug);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_count !== 10'd0) $display("FAIL reset_count: got %0d expected 0", bus.dug_count);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_state !== '0) $display("FAIL reset_map: got %0h expected 0", bus.dug_state);
        else pass_cnt++;
        Reset = 1'b1;
        tick(4);
    endtask

    task automatic test_dig_first();
        bus.Player_X = 10'd130; bus.Player_Y = 10'd100; bus.dig_en = 1'b1;
        pulse_cnt = 0;
        frame_pulse();          // edge sampled, frame_edge registered
        total_cnt++;
        if (bus.dug_state[8][0] !== 1'b0) $display("FAIL dig_early: got %0b expected 0", bus.dug_state[8][0]);
        else pass_cnt++;
        tick();                 // edge consumed: tile written
        total_cnt++;
        if (bus.tile_dug !== 1'b1) $display("FAIL dig_pulse_hi: got %0b expected 1", bus.tile_dug);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.tile_dug !== 1'b0) $display("FAIL dig_pulse_lo: got %0b expected 0", bus.tile_dug);
        else pass_cnt++;
        tick(3);
        exp_map = '0;
        exp_map[8][0] = 1'b1;
        total_cnt++;
        if (bus.dug_state !== exp_map) $display("FAIL dig_map: got %0h expected %0h", bus.dug_state, exp_map);
        else pass_cnt++;
        total_cnt++;
        if (pulse_cnt != 1) $display("FAIL dig_pulses: got %0d expected 1", pulse_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_count !== 10'd1) $display("FAIL dig_count: got %0d expected 1", bus.dug_count);
        else pass_cnt++;
    endtask

    task automatic test_dig_repeat();
        pulse_cnt = 0;
        frame_pulse();
        tick(5);
        total_cnt++;
        if (pulse_cnt != 0) $display("FAIL repeat_pulses: got %0d expected 0", pulse_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_count !== 10'd1) $display("FAIL repeat_count: got %0d expected 1", bus.dug_count);
        else pass_cnt++;
    endtask

    task automatic count_busy(input string name, input int unsigned want);
        int unsigned n;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total_cnt++;
        if (n != want) $display("FAIL %s: got %0d busy cycles expected %0d", name, n, want);
        else pass_cnt++;
    endtask

    task automatic test_level_load();
        bus.dig_en = 1'b0;
        bus.level_load = 1'b1;
        tick();
        bus.level_load = 1'b0;
        count_busy("load_busy_len", 32);
        exp_map = '0;
        exp_map[16] = 24'h00000F;
        total_cnt++;
        if (bus.dug_state !== exp_map) $display("FAIL load_map: got %0h expected %0h", bus.dug_state, exp_map);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_count !== 10'd4) $display("FAIL load_count: got %0d expected 4", bus.dug_count);
        else pass_cnt++;
    endtask

    task automatic test_sweep_restart();
        bus.level_load = 1'b1;
        tick();
        bus.level_load = 1'b0;
        tick(5);
        bus.level_load = 1'b1;
        tick();
        bus.level_load = 1'b0;
        count_busy("restart_busy_len", 32);
        total_cnt++;
        if (bus.dug_count !== 10'd4) $display("FAIL restart_count: got %0d expected 4", bus.dug_count);
        else pass_cnt++;
    endtask

    task automatic test_out_of_map();
        pulse_cnt = 0;
        bus.dig_en = 1'b1;
        bus.Player_X = 10'd130; bus.Player_Y = 10'd90;
        frame_pulse();
        tick(4);
        bus.Player_X = 10'd600; bus.Player_Y = 10'd100;
        frame_pulse();
        tick(4);
        bus.Player_X = 10'd130; bus.Player_Y = 10'd480;
        frame_pulse();
        tick(4);
        total_cnt++;
        if (bus.dug_state !== exp_map) $display("FAIL oom_map: got %0h expected %0h", bus.dug_state, exp_map);
        else pass_cnt++;
        total_cnt++;
        if (pulse_cnt != 0) $display("FAIL oom_pulses: got %0d expected 0", pulse_cnt);
        else pass_cnt++;
    endtask

    task automatic test_load_vs_dig_and_reset();
        pulse_cnt = 0;
        bus.dig_en = 1'b1;
        bus.Player_X = 10'd40; bus.Player_Y = 10'd100;
        frame_pulse();           // frame_edge now registered high
        bus.level_load = 1'b1;
        tick();                  // load and frame edge consumed together
        bus.level_load = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL collide_busy: got %0b expected 1", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (pulse_cnt != 0 || bus.tile_dug !== 1'b0) $display("FAIL collide_pulse: got %0d pulses expected 0", pulse_cnt);
        else pass_cnt++;
        tick(10);
        Reset = 1'b0;
        #1;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %0b expected 0", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_state !== '0) $display("FAIL midreset_map: got %0h expected 0", bus.dug_state);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_count !== 10'd0) $display("FAIL midreset_count: got %0d expected 0", bus.dug_count);
        else pass_cnt++;
        bus.dig_en = 1'b0;
        tick(2);
        Reset = 1'b1;
        tick(40);
        total_cnt++;
        if (bus.dug_state !== '0 || bus.busy !== 1'b0) $display("FAIL postreset_map: got %0h busy %0b expected 0 busy 0", bus.dug_state, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_rocks_below();
        logic [9:0] rock_row;
        pulse_cnt = 0;
        bus.dig_en = 1'b1;
        bus.Player_X = 10'd200; bus.Player_Y = 10'd128;
        frame_pulse();
        tick(4);
        rock_row = (10'd112 - 10'd96) >> 4;
        total_cnt++;
        if (bus.dug_state[12][2] !== 1'b1) $display("FAIL rocks_tile: got %0b expected 1", bus.dug_state[12][2]);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_state[12][rock_row + 10'd1] !== 1'b1) $display("FAIL rocks_below: got %0b expected 1", bus.dug_state[12][rock_row + 10'd1]);
        else pass_cnt++;
        total_cnt++;
        if (bus.dug_count !== 10'd1 || pulse_cnt != 1) $display("FAIL rocks_count: got %0d/%0d expected 1/1", bus.dug_count, pulse_cnt);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        pulse_cnt = 0;
        test_reset();
        test_dig_first();
        test_dig_repeat();
        test_level_load();
        test_sweep_restart();
        test_out_of_map();
        test_load_vs_dig_and_reset();
        test_rocks_below();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dig_map.md
DIG_MAP -- requirements
Module: dig_map

Interface
REQ-001 SHALL have parameter MAP_TOP, default 10'd96, meaning pixel Y of tile row 0.
REQ-002 SHALL have parameter START_COL, default 5'd16, meaning the column pre-dug (rows 0-3) after every level load.
REQ-003 Clk  input  1  system clock; all state SHALL be clocked on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 frame_clk  input  1  vertical-sync frame tick; sampled on Clk, used only via rising-edge detect.
REQ-006 Player_X  input  10  player centre pixel X.
REQ-007 Player_Y  input  10  player centre pixel Y.
REQ-008 dig_en  input  1  player is moving/digging this frame.
REQ-009 level_load  input  1  single-cycle request to reinitialise the map.
REQ-010 dug_state  output  [23:0] x 32  tunnel bitmap; dug_state[col][row]=1 means tile dug; feeds Rocks.
REQ-011 busy  output  1  map reinitialisation sweep in progress.
REQ-012 tile_dug  output  1  one-Clk pulse when a new tile becomes dug.
REQ-013 dug_count  output  10  number of tiles dug since last load/reset.

Function
REQ-014 Tile mapping SHALL be col = Player_X[8:4], row = (Player_Y - MAP_TOP) >> 4, unsigned 10-bit subtract.
REQ-015 Position SHALL be in-map only if Player_X <= 511 and MAP_TOP <= Player_Y <= MAP_TOP+383; otherwise no write.
REQ-016 Frame edge SHALL be detected as frame_edge <= frame_clk & ~frame_clk_d, with frame_clk_d <= frame_clk, both registered.
REQ-017 FSM SHALL have states RUN and SWEEP; reset state RUN.
REQ-018 In RUN, level_load=1 SHALL transition to SWEEP with sweep column counter sc = 0.
REQ-019 In SWEEP, each Clk SHALL write dug_state[sc] = 24'h0, except sc == START_COL writes 24'h00000F; sc then increments.
REQ-020 SWEEP SHALL last exactly 32 Clks (sc 0..31); after sc=31 the state SHALL return to RUN and dug_count SHALL equal 4.
REQ-021 busy SHALL be 1 exactly while state == SWEEP.
REQ-022 In RUN, when frame_edge=1, dig_en=1 and position is in-map, dug_state[col][row] SHALL be set on the same Clk edge that consumes frame_edge.
REQ-023 If that tile was already 1, nothing SHALL change: no tile_dug pulse, no count increment.
REQ-024 If the tile was 0, tile_dug SHALL be 1 for exactly the following Clk cycle, and dug_count SHALL increment by 1, saturating at 768.
REQ-025 At most one tile SHALL be written per frame edge.
REQ-026 Simultaneous level_load and frame_edge in RUN: the load SHALL win and the dig SHALL be dropped.
REQ-027 level_load during SWEEP SHALL restart the sweep with sc = 0.
REQ-028 frame_edge during SWEEP SHALL be ignored.
REQ-029 dug_state SHALL be a registered output; no combinational path from inputs to dug_state.

Reset
REQ-030 Reset=0 SHALL immediately, without Clk, clear all of: dug_state (all bits), the count, FSM state (to RUN), sc, and the frame_clk_d and frame_edge registers.
REQ-031 Reset reset values SHALL be: dug_state all 0, busy 0, tile_dug 0, dug_count 0, state RUN.
REQ-032 Reset asserted mid-SWEEP SHALL abort the sweep; after release the block SHALL be in RUN with an all-zero map, with no START_COL pre-dig.
REQ-033 Reset release SHALL be synchronised into Clk so that state leaves reset on a clean edge.

Verification
REQ-034 Reset, then Player_X=130, Player_Y=100, dig_en=1, one frame_clk pulse -> 2 Clks after frame_clk is sampled high: dug_state[8][0]=1, tile_dug pulses once, dug_count=1.
REQ-035 Repeat the same position for a second frame pulse -> no tile_dug pulse, dug_count stays 1.
REQ-036 Pulse level_load -> busy=1 for 32 Clks, then: dug_state[16]=24'h00000F, all other columns 0, dug_count=4.
REQ-037 Player_Y=90 or Player_X=600 with dig_en=1 and a frame pulse -> map unchanged, no tile_dug.
REQ-038 level_load and frame_edge in the same cycle -> dig dropped and sweep runs; assert Reset=0 at sweep cycle 10 -> async clear of all outputs, busy=0.
REQ-039 Dig Player_X=200, Player_Y=128 -> dug_state[12][2]=1; the Rocks stage sitting at X=200, Y=112 sees its below-tile as dug.
